// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage ALU.
//   - 4-bit ALU control codes driven to the ALU mux
//   - 2-bit ALUOp values from main control
//   - 11-bit R-type opcode values found in ins[31:21]
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    // ALUOp from main control
    localparam logic [1:0] ALUOP_MEM  = 2'b00;  // loads/stores: address add
    localparam logic [1:0] ALUOP_CBZ  = 2'b01;  // compare-and-branch: pass B
    localparam logic [1:0] ALUOP_RTYP = 2'b10;  // decode from opcode field
    localparam logic [1:0] ALUOP_RSV  = 2'b11;  // reserved

    // R-type opcodes, ins[31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_LSL = 11'b11010011011;
    localparam logic [10:0] OPC_LSR = 11'b11010011010;

endpackage

// File: rtl/adder64.sv
// adder64: DATA_W-bit adder with carry-in and carry-out.
// Ports:
//   a, b  : addends
//   cin   : carry-in
//   sum   : a + b + cin modulo 2^DATA_W
//   cout  : carry-out of the top bit
module adder64 #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage of the LEGv8-style pipeline. Decodes ALU
// control, runs the ALU and the branch-target adder, and registers all
// results (acts as the EX/MEM capture point). One cycle latency.
// Optional feature macro: ALU_SHIFT_EN (adds LSL/LSR R-type decode).
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   in_valid            : capture enable for this cycle's inputs
//   ins                 : instruction (opcode ins[31:21], shamt ins[15:10])
//   alu_op, alu_src     : ALUOp and operand-B select from main control
//   data_a, data_b, imm : operands and sign-extended immediate
//   pc                  : instruction PC
//   out_valid           : registered in_valid
//   alu_ctrl, alu_res   : registered control code and ALU result
//   alu_zero, alu_carry : registered ALU flags
//   br_target, br_carry : registered pc + (imm << BR_SHIFT) and its carry
//   illegal_op          : registered flag, decode fell to default
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [31:0]       ins,
    input  logic [1:0]        alu_op,
    input  logic              alu_src,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_res,
    output logic              alu_zero,
    output logic              alu_carry,
    output logic [DATA_W-1:0] br_target,
    output logic              br_carry,
    output logic              illegal_op
);

    logic [10:0] opcode;
    logic [5:0]  shamt;
    assign opcode = ins[31:21];
    assign shamt  = ins[15:10];

    // Fields of ins this block never looks at.
    logic unused_ins;
    assign unused_ins = ^{ins[20:0]};

    // ---------------- decode ----------------
    logic [3:0] ctrl_d;
    logic       ill_d;

    always_comb begin
        ctrl_d = ALU_ADD;
        ill_d  = 1'b0;
        case (alu_op)
            ALUOP_MEM: ctrl_d = ALU_ADD;
            ALUOP_CBZ: ctrl_d = ALU_PASSB;
            ALUOP_RTYP: begin
                case (opcode)
                    OPC_ADD: ctrl_d = ALU_ADD;
                    OPC_SUB: ctrl_d = ALU_SUB;
                    OPC_AND: ctrl_d = ALU_AND;
                    OPC_ORR: ctrl_d = ALU_ORR;
`ifdef ALU_SHIFT_EN
                    OPC_LSL: ctrl_d = ALU_LSL;
                    OPC_LSR: ctrl_d = ALU_LSR;
`endif
                    default: begin
                        ctrl_d = ALU_ADD;
                        ill_d  = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_d = ALU_ADD;
                ill_d  = 1'b1;
            end
        endcase
    end

    // ---------------- ALU ----------------
    logic [DATA_W-1:0] op_b;
    assign op_b = alu_src ? imm : data_b;

    // Shared add/sub: SUB is A + ~B + 1, so carry-out = "no borrow".
    logic              is_sub;
    logic [DATA_W-1:0] addsub_b;
    logic [DATA_W-1:0] addsub_sum;
    logic              addsub_cout;
    assign is_sub   = (ctrl_d == ALU_SUB);
    assign addsub_b = is_sub ? ~op_b : op_b;

    adder64 #(.DATA_W(DATA_W)) u_alu_add (
        .a    (data_a),
        .b    (addsub_b),
        .cin  (is_sub),
        .sum  (addsub_sum),
        .cout (addsub_cout)
    );

    logic [DATA_W-1:0] res_d;
    logic              carry_d;

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        case (ctrl_d)
            ALU_AND:   res_d = data_a & op_b;
            ALU_ORR:   res_d = data_a | op_b;
            ALU_ADD, ALU_SUB: begin
                res_d   = addsub_sum;
                carry_d = addsub_cout;
            end
            ALU_PASSB: res_d = op_b;
            ALU_NOR:   res_d = ~(data_a | op_b);
`ifdef ALU_SHIFT_EN
            ALU_LSL:   res_d = data_a << shamt;
            ALU_LSR:   res_d = data_a >> shamt;
`endif
            default:   res_d = '0;
        endcase
    end

    // ---------------- branch target ----------------
    logic [DATA_W-1:0] imm_sh;
    logic [DATA_W-1:0] br_d;
    logic              br_c_d;
    assign imm_sh = imm << BR_SHIFT;

    adder64 #(.DATA_W(DATA_W)) u_br_add (
        .a    (pc),
        .b    (imm_sh),
        .cin  (1'b0),
        .sum  (br_d),
        .cout (br_c_d)
    );

    // ---------------- output registers ----------------
    // out_valid tracks in_valid every cycle; the payload holds when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            alu_ctrl   <= '0;
            alu_res    <= '0;
            alu_zero   <= 1'b0;
            alu_carry  <= 1'b0;
            br_target  <= '0;
            br_carry   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_ctrl   <= ctrl_d;
                alu_res    <= res_d;
                alu_zero   <= (res_d == '0);
                alu_carry  <= carry_d;
                br_target  <= br_d;
                br_carry   <= br_c_d;
                illegal_op <= ill_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Table-driven bench for alu_exec_unit plus hand sequences for hold and
// asynchronous reset. Honours ALU_SHIFT_EN to pick shift expectations.
module tb_alu_exec_unit;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [31:0]  ins;
    logic [1:0]   alu_op;
    logic         alu_src;
    logic [W-1:0] data_a, data_b, imm, pc;
    logic         out_valid;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_res;
    logic         alu_zero, alu_carry;
    logic [W-1:0] br_target;
    logic         br_carry, illegal_op;

    alu_exec_unit dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .ins(ins),
        .alu_op(alu_op), .alu_src(alu_src), .data_a(data_a), .data_b(data_b),
        .imm(imm), .pc(pc), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .br_target(br_target), .br_carry(br_carry), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic         src;
        logic [31:0]  ins;
        logic [W-1:0] a, b, imm, pc;
        logic [3:0]   e_ctrl;
        logic [W-1:0] e_res;
        logic         e_zero, e_carry;
        logic [W-1:0] e_br;
        logic         e_brc, e_ill;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk_ins(input logic [10:0] opc, input logic [5:0] sh);
        return {opc, 5'd0, sh, 10'd0};
    endfunction

    function automatic vec_t mk(input string nm, input logic [1:0] op, input logic src,
                                input logic [31:0] in_s, input logic [W-1:0] a, b, im, p,
                                input logic [3:0] ec, input logic [W-1:0] er,
                                input logic ez, ecy, input logic [W-1:0] eb,
                                input logic ebc, eil);
        vec_t v;
        v.name = nm; v.op = op; v.src = src; v.ins = in_s;
        v.a = a; v.b = b; v.imm = im; v.pc = p;
        v.e_ctrl = ec; v.e_res = er; v.e_zero = ez; v.e_carry = ecy;
        v.e_br = eb; v.e_brc = ebc; v.e_ill = eil;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        in_valid = vld; alu_op = v.op; alu_src = v.src; ins = v.ins;
        data_a = v.a; data_b = v.b; imm = v.imm; pc = v.pc;
    endtask

    task automatic check_vec(input vec_t v, input logic e_vld);
        chk({v.name, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_vld});
        chk({v.name, ".alu_ctrl"},  {60'd0, alu_ctrl},  {60'd0, v.e_ctrl});
        chk({v.name, ".alu_res"},   alu_res,            v.e_res);
        chk({v.name, ".alu_zero"},  {63'd0, alu_zero},  {63'd0, v.e_zero});
        chk({v.name, ".alu_carry"}, {63'd0, alu_carry}, {63'd0, v.e_carry});
        chk({v.name, ".br_target"}, br_target,          v.e_br);
        chk({v.name, ".br_carry"},  {63'd0, br_carry},  {63'd0, v.e_brc});
        chk({v.name, ".illegal"},   {63'd0, illegal_op},{63'd0, v.e_ill});
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v, 1'b1);
        @(posedge clk);
        #1;
        check_vec(v, 1'b1);
    endtask

    vec_t zero_v, last_v, junk_v;

    initial begin
        // opcode constants
        logic [10:0] o_add, o_sub, o_and, o_orr, o_lsl, o_lsr, o_bad;
        o_add = 11'b10001011000; o_sub = 11'b11001011000;
        o_and = 11'b10001010000; o_orr = 11'b10101010000;
        o_lsl = 11'b11010011011; o_lsr = 11'b11010011010;
        o_bad = 11'b11111111111;

        zero_v = mk("reset", 2'b00, 1'b0, 32'd0, 0, 0, 0, 0, 4'd0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        vecs.push_back(mk("r_add", 2'b10, 0, mk_ins(o_add, 0), 5, 7, 0, 0,
                          4'b0010, 12, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sub_zero", 2'b10, 0, mk_ins(o_sub, 0), 64'h10, 64'h10, 0, 0,
                          4'b0110, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("sub_borrow", 2'b10, 0, mk_ins(o_sub, 0), 0, 1, 0, 0,
                          4'b0110, ONES, 0, 0, 0, 0, 0));
        vecs.push_back(mk("load_addr", 2'b00, 1, 32'd0, 100, 999, 8, 64'h40,
                          4'b0010, 108, 0, 0, 64'h60, 0, 0));
        vecs.push_back(mk("cbz_zero", 2'b01, 0, 32'd0, 55, 0, 0, 0,
                          4'b0111, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("br_wrap", 2'b01, 0, 32'd0, 55, 3, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                          4'b0111, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk("r_and", 2'b10, 0, mk_ins(o_and, 0), 64'hF0F0, 64'hFF00, 0, 0,
                          4'b0000, 64'hF000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("r_orr", 2'b10, 0, mk_ins(o_orr, 0), 64'hF0, 64'h0F, 0, 0,
                          4'b0001, 64'hFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("add_carry", 2'b10, 0, mk_ins(o_add, 0), ONES, 1, 0, 0,
                          4'b0010, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("neg_imm", 2'b00, 1, 32'd0, 64'h1000, 0, ONES, 64'h100,
                          4'b0010, 64'hFFF, 0, 1, 64'hFC, 1, 0));
        vecs.push_back(mk("rsv_op", 2'b11, 0, 32'd0, 1, 1, 0, 0,
                          4'b0010, 2, 0, 0, 0, 0, 1));
`ifdef ALU_SHIFT_EN
        vecs.push_back(mk("lsl", 2'b10, 0, mk_ins(o_lsl, 4), 1, 2, 0, 0,
                          4'b0011, 16, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lsr", 2'b10, 0, mk_ins(o_lsr, 4), 64'h100, 2, 0, 0,
                          4'b0100, 64'h10, 0, 0, 0, 0, 0));
`else
        vecs.push_back(mk("lsl_ill", 2'b10, 0, mk_ins(o_lsl, 4), 1, 2, 0, 0,
                          4'b0010, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lsr_ill", 2'b10, 0, mk_ins(o_lsr, 4), 64'h100, 2, 0, 0,
                          4'b0010, 64'h102, 0, 0, 0, 0, 1));
`endif
        // Last entry: illegal R-type, reused by the hold sequence below.
        vecs.push_back(mk("illegal", 2'b10, 0, mk_ins(o_bad, 0), 2, 3, 1, 64'h8,
                          4'b0010, 5, 0, 0, 64'hC, 0, 1));

        junk_v = mk("junk", 2'b10, 0, mk_ins(o_sub, 0), 64'h77, 64'h77, 5, 64'h1234,
                    0, 0, 0, 0, 0, 0, 0);

        // Reset state
        reset_n = 1'b0;
        drive(zero_v, 1'b0);
        #12;
        check_vec(zero_v, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_vec(zero_v, 1'b0);

        // Table
        foreach (vecs[i]) apply(vecs[i]);
        last_v = vecs[vecs.size()-1];

        // Hold: in_valid low with different inputs leaves payload alone
        @(negedge clk);
        drive(junk_v, 1'b0);
        @(posedge clk);
        #1;
        check_vec(last_v, 1'b0);

        // Async reset mid-stream: clears between edges
        apply(vecs[0]);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec(zero_v, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(junk_v, 1'b0);
        @(posedge clk);
        #1;
        check_vec(zero_v, 1'b0);

        // Recovery after reset
        apply(vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
